pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipelined MIPS CPU (IF/ID/EX/MEM/WB).
- Detects load-use hazards, squashes wrong-path instructions after taken branches and jumps, and freezes the whole pipeline for multi-cycle data-memory accesses.
- Drives the write-enable and flush controls of the PC and all pipeline registers.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- MEM_LAT, 1: data-memory access latency in cycles (>=1); 1 means no freeze.
- CNT_W, 16: width of performance counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ifid_rs_i  in  5  rs field of the instruction in ID
- ifid_rt_i  in  5  rt field of the instruction in ID
- ifid_uses_rt_i  in  1  ID instruction reads rt (R-type, beq/bne, sw)
- idex_memread_i  in  1  instruction in EX is a load
- idex_rt_i  in  5  destination rt of the load in EX
- jump_i  in  1  j/jal/jr decoded in ID (target known in ID)
- branch_taken_i  in  1  branch resolved taken in MEM stage
- mem_access_i  in  1  MEM-stage instruction has MemRead or MemWrite
- pc_write_o  out  1  PC update enable
- ifid_write_o  out  1  IF/ID register update enable
- ifid_flush_o  out  1  IF/ID loads NOP
- idex_flush_o  out  1  ID/EX loads bubble (all control zero)
- exmem_flush_o  out  1  EX/MEM loads bubble
- freeze_o  out  1  hold every pipeline register, including MEM/WB
- stall_cycles_o  out  CNT_W  count of cycles with pc_write_o=0
- flush_events_o  out  CNT_W  count of cycles with ifid_flush_o=1

Behaviour:
- States: RUN, MEM_WAIT. Wait counter wcnt is $clog2(MEM_LAT)+1 bits wide.
- Reset (synchronous): state=RUN, wcnt=0, both perf counters=0.
- Outputs are combinational from state, wcnt and inputs. During rst_i high: pc_write_o=1, ifid_write_o=1, all flush and freeze outputs=0.
- Default outputs: pc_write_o=1, ifid_write_o=1, all flush outputs=0, freeze_o=0.
- Priority, highest first: freeze > branch flush > load-use stall > jump flush.

Freeze (memory wait):
- RUN with mem_access_i=1 and MEM_LAT>1: freeze_o=1, pc_write_o=0, ifid_write_o=0. Next state MEM_WAIT, wcnt=MEM_LAT-2.
- MEM_WAIT with wcnt!=0: freeze_o=1, pc_write_o=0, ifid_write_o=0, wcnt decrements.
- MEM_WAIT with wcnt==0: freeze released, the access completes, the normal rules below apply this cycle, next state RUN.
- Total freeze length per access is exactly MEM_LAT-1 cycles.
- While frozen, every flush output is 0 and branch_taken_i, jump_i and the load-use condition are ignored. They are re-evaluated on the release cycle.
- MEM_LAT=1: state never leaves RUN and freeze_o is constantly 0.

Branch flush:
- When branch_taken_i=1: ifid_flush_o=1, idex_flush_o=1, exmem_flush_o=1, pc_write_o=1, ifid_write_o=1.
- A coincident load-use stall or jump is squashed; the branch wins.

Load-use stall:
- Condition: idex_memread_i=1, idex_rt_i!=0, and either idex_rt_i==ifid_rs_i or (ifid_uses_rt_i=1 and idex_rt_i==ifid_rt_i).
- Response: pc_write_o=0, ifid_write_o=0, idex_flush_o=1 for exactly one cycle. The load advances, so the condition clears on its own.
- jump_i in the same cycle: jump flush is suppressed, which covers jr depending on the load. The jump takes effect the next cycle.

Jump flush:
- When jump_i=1 and no higher-priority event: ifid_flush_o=1 only.

Counters:
- stall_cycles_o increments on every cycle with pc_write_o=0 and rst_i=0.
- flush_events_o increments on every cycle with ifid_flush_o=1.
- Both saturate at all-ones and never wrap.

Test Plan:
- Reset: rst_i=1 for 2 cycles with mem_access_i=1 -> state RUN, counters 0, pc_write_o=1, freeze_o=0. After release with MEM_LAT=3, freeze_o=1 in exactly 2 consecutive cycles.
- Load-use: idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8 -> one cycle of pc_write_o=0, ifid_write_o=0, idex_flush_o=1; stall_cycles_o=1. Repeat with idex_rt_i=0 -> no stall.
- rt dependence: idex_rt_i=9, ifid_rt_i=9 -> with ifid_uses_rt_i=1 stall occurs; with ifid_uses_rt_i=0 no stall.
- Branch vs load-use: branch_taken_i=1 together with a load-use condition -> ifid/idex/exmem flush all 1, pc_write_o=1, flush_events_o +1, stall_cycles_o unchanged.
- Memory wait, MEM_LAT=4: mem_access_i=1 held, branch_taken_i=1 on the 2nd frozen cycle -> freeze_o=1 for 3 cycles with all flushes 0. Branch is honoured on the release cycle only if still asserted.
- Saturation, CNT_W=4: 20 consecutive load-use stall cycles -> stall_cycles_o holds at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use stalls, branch/jump
// squashing, multi-cycle data-memory freeze and saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic             jump_i,
    input  logic             branch_taken_i,
    input  logic             mem_access_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             exmem_flush_o,
    output logic             freeze_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_events_o
);

    localparam int WW = $clog2(MEM_LAT) + 1;
    localparam logic [WW-1:0] WAIT_INIT = WW'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
    localparam logic MULTI_CYCLE = (MEM_LAT > 1);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    state_t        state;
    logic [WW-1:0] wcnt;
    logic          load_use;
    logic          frozen;

    always_comb begin
        load_use = idex_memread_i && (idex_rt_i != '0) &&
                   ((idex_rt_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

        // The release cycle (MEM_WAIT, wcnt==0) is not frozen and does not re-arm on mem_access_i.
        frozen = 1'b0;
        if (!rst_i) begin
            if (state == RUN) begin
                frozen = mem_access_i && MULTI_CYCLE;
            end else begin
                frozen = (wcnt != '0);
            end
        end

        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        freeze_o      = 1'b0;

        if (rst_i) begin
            pc_write_o = 1'b1;
        end else if (frozen) begin
            freeze_o     = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else if (branch_taken_i) begin
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
        end else if (load_use) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
        end else if (jump_i) begin
            ifid_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= RUN;
            wcnt           <= '0;
            stall_cycles_o <= '0;
            flush_events_o <= '0;
        end else begin
            if (state == RUN) begin
                if (mem_access_i && MULTI_CYCLE) begin
                    state <= MEM_WAIT;
                    wcnt  <= WAIT_INIT;
                end
            end else begin
                if (wcnt != '0) begin
                    wcnt <= wcnt - WW'(1);
                end else begin
                    state <= RUN;
                end
            end

            if (!pc_write_o && (stall_cycles_o != '1)) begin
                stall_cycles_o <= stall_cycles_o + CNT_W'(1);
            end
            if (ifid_flush_o && (flush_events_o != '1)) begin
                flush_events_o <= flush_events_o + CNT_W'(1);
            end
        end
    end

endmodule
